mm_addr_seq: RTL

MM_ADDR_SEQ -- requirements
Module: mm_addr_seq

---
 rtl/mm_addr_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/mm_addr_seq.sv
// mm_addr_seq: matmul address sequencer issuing dim/A/B/C memory requests over a ready handshake, pulsing mm_en per C block, reporting busy/mm_complete/err_dim
module mm_addr_seq #(
  parameter int ADDR_W = 32,
  parameter int M_W = 11,
  parameter int N_W = 11,
  parameter int O_W = 10,
  parameter int BLK = 8,
  parameter logic [ADDR_W-1:0] BASE_A = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] BASE_B = 32'h0000_1400,
  parameter logic [ADDR_W-1:0] BASE_C = 32'h0000_2800,
  parameter logic [ADDR_W-1:0] DIM_ADDR = 32'h0000_3C00
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [M_W+N_W+O_W-1:0] dim_in,
  input  logic mem_ready,
  input  logic mac_done,
  output logic mem_req,
  output logic mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0] op,
  output logic mm_en,
  output logic busy,
  output logic mm_complete,
  output logic err_dim
);
  localparam int LB = $clog2(BLK);
  typedef enum logic [2:0] {IDLE, DIM, CHECK, REQ_A, REQ_B, MAC, REQ_C, DONE} state_t;
  state_t state;
  logic [M_W-1:0] m, i;
  logic [N_W-1:0] n, kb;
  logic [O_W-1:0] o, jb;
  logic [LB-1:0] r;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr, req_addr;
  logic [2:0] req_op;
  logic kb_last, jb_last, i_last, bad_dim, req_state;
  always_comb begin
    a_addr = BASE_A + ((ADDR_W'(i) * ADDR_W'(n) + ADDR_W'(kb) * ADDR_W'(BLK)) << 2);
    b_addr = BASE_B + (((ADDR_W'(kb) * ADDR_W'(BLK) + ADDR_W'(r)) * ADDR_W'(o) + ADDR_W'(jb) * ADDR_W'(BLK)) << 2);
    c_addr = BASE_C + ((ADDR_W'(i) * ADDR_W'(o) + ADDR_W'(jb) * ADDR_W'(BLK)) << 2);
    req_addr = state == DIM ? DIM_ADDR : state == REQ_A ? a_addr : state == REQ_B ? b_addr : c_addr;
    req_op = state == DIM ? 3'd0 : state == REQ_A ? 3'd1 : state == REQ_B ? 3'd2 : 3'd3;
    req_state = state == DIM || state == REQ_A || state == REQ_B || state == REQ_C;
    kb_last = kb == N_W'((n >> LB) - 1'b1);
    jb_last = jb == O_W'((o >> LB) - 1'b1);
    i_last = i == m - 1'b1;
    bad_dim = m == '0 || n == '0 || o == '0 || n[LB-1:0] != '0 || o[LB-1:0] != '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      {m, n, o, i, kb, jb, r} <= '0;
      {mem_req, mem_we, mem_addr, op, mm_en, busy, mm_complete, err_dim} <= '0;
    end else begin
      mm_en <= 1'b0;
      if (req_state && !mem_req) begin
        mem_req <= 1'b1;
        mem_addr <= req_addr;
        op <= req_op;
        mem_we <= state == REQ_C;
      end else begin
        case (state)
          IDLE, DONE: if (start) begin
            state <= DIM;
            busy <= 1'b1;
            mm_complete <= 1'b0;
            err_dim <= 1'b0;
          end
          DIM: if (mem_ready) begin
            mem_req <= 1'b0;
            m <= dim_in[M_W-1:0];
            n <= dim_in[M_W+:N_W];
            o <= dim_in[M_W+N_W+:O_W];
            state <= CHECK;
          end
          CHECK: if (bad_dim) begin
            state <= DONE;
            err_dim <= 1'b1;
            mm_complete <= 1'b1;
            busy <= 1'b0;
          end else begin
            {i, kb, jb, r} <= '0;
            state <= REQ_A;
          end
          REQ_A: if (mem_ready) begin
            mem_req <= 1'b0;
            r <= '0;
            state <= REQ_B;
          end
          REQ_B: if (mem_ready) begin
            mem_req <= 1'b0;
            r <= r + 1'b1;
            if (r == LB'(BLK - 1)) begin
              kb <= kb_last ? '0 : kb + 1'b1;
              state <= kb_last ? MAC : REQ_A;
              mm_en <= kb_last;
            end
          end
          MAC: if (mac_done) state <= REQ_C;
          REQ_C: if (mem_ready) begin
            mem_req <= 1'b0;
            jb <= jb_last ? '0 : jb + 1'b1;
            i <= jb_last ? i + 1'b1 : i;
            state <= jb_last && i_last ? DONE : REQ_A;
            busy <= !(jb_last && i_last);
            mm_complete <= jb_last && i_last;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
